// File: rtl/core_pkg.sv
// Shared types for the pipeline controller: forwarding selects and FSM states.
package core_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN   = 1'b0,
    DWAIT = 1'b1
  } pctrl_state_t;

  localparam int unsigned REG_W = 5;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one E-stage source operand; the younger M result beats W.
module fwd_unit
  import core_pkg::*;
(
  input  logic [REG_W-1:0] i_src,
  input  logic [REG_W-1:0] i_wreg_m,
  input  logic             i_rw_m,
  input  logic [REG_W-1:0] i_wreg_w,
  input  logic             i_rw_w,
  output fwd_sel_t         o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_rw_m && (i_wreg_m != '0) && (i_wreg_m == i_src)) begin
      o_sel = FWD_M;
    end else if (i_rw_w && (i_wreg_w != '0) && (i_wreg_w == i_src)) begin
      o_sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stalls, flushes,
// dmem wait freeze with watchdog, forwarding selects and perf counters.
module pipe_ctrl
  import core_pkg::*;
#(
  parameter int unsigned DWAIT_MAX = 16,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeregE,
  input  logic [4:0]       writeregM,
  input  logic [4:0]       writeregW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             memtoregE,
  input  logic             redirectE,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             enF,
  output logic             enD,
  output logic             enE,
  output logic             enM,
  output logic             enW,
  output logic             clrD,
  output logic             clrE,
  output logic             clrM,
  output logic             clrW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WCW = $clog2(DWAIT_MAX + 1);

  pctrl_state_t     r_state;
  pctrl_state_t     w_next;
  logic             w_lu;
  logic             w_freeze;
  logic             w_flush;
  logic [4:0]       w_en;
  logic [3:0]       w_clr;
  fwd_sel_t         w_fwd_a;
  fwd_sel_t         w_fwd_b;
  logic [WCW-1:0]   r_wcnt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall;
  logic [CNT_W-1:0] r_flush;

  fwd_unit u_fwd_a (
    .i_src    (rsE),
    .i_wreg_m (writeregM),
    .i_rw_m   (regwriteM),
    .i_wreg_w (writeregW),
    .i_rw_w   (regwriteW),
    .o_sel    (w_fwd_a)
  );

  fwd_unit u_fwd_b (
    .i_src    (rtE),
    .i_wreg_m (writeregM),
    .i_rw_m   (regwriteM),
    .i_wreg_w (writeregW),
    .i_rw_w   (regwriteW),
    .o_sel    (w_fwd_b)
  );

  // regwriteE is implied by memtoregE for a load, so only the load flag gates lu.
  assign w_lu = memtoregE && (writeregE != '0) &&
                ((writeregE == rsD) || (writeregE == rtD));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_en     = '0;
    w_clr    = '0;
    w_flush  = 1'b0;
    // The completion cycle (dmem_ready=1) is not frozen, even in DWAIT.
    w_freeze = !dmem_ready && ((r_state == DWAIT) || dmem_req);

    case (r_state)
      RUN:     if (dmem_req && !dmem_ready) w_next = DWAIT;
      DWAIT:   if (dmem_ready) w_next = RUN;
      default: w_next = RUN;
    endcase

    if (w_freeze) begin
      w_en  = 5'b11110;
      w_clr = 4'b0001;
    end else if (redirectE) begin
      w_clr   = 4'b1100;
      w_flush = 1'b1;
    end else if (w_lu) begin
      w_en    = 5'b11000;
      w_clr   = 4'b0100;
      w_flush = 1'b1;
    end else if (!imem_ready) begin
      w_en  = 5'b10000;
      w_clr = 4'b1000;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wcnt    <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == DWAIT) begin
      if (r_wcnt != WCW'(DWAIT_MAX)) r_wcnt <= r_wcnt + WCW'(1);
      if (r_wcnt >= WCW'(DWAIT_MAX - 1)) r_timeout <= 1'b1;
    end else if (w_next == DWAIT) begin
      r_wcnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      r_stall <= r_stall + CNT_W'(w_en[4]);
      r_flush <= r_flush + CNT_W'(w_flush);
    end
  end

  // Combinational outputs are forced to reset values while reset is asserted.
  assign {enF, enD, enE, enM, enW} = reset ? w_en  : '0;
  assign {clrD, clrE, clrM, clrW}  = reset ? w_clr : '0;
  assign forwardAE   = reset ? w_fwd_a : FWD_RF;
  assign forwardBE   = reset ? w_fwd_b : FWD_RF;
  assign mem_timeout = r_timeout;
  assign stall_cnt   = r_stall;
  assign flush_cnt   = r_flush;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed + randomized bench for pipe_ctrl against a behavioural model.
module tb_pipe_ctrl;

  localparam int unsigned DWAIT_MAX = 4;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned CNT_MOD   = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic             regwriteE, regwriteM, regwriteW, memtoregE, redirectE;
  logic             imem_ready, dmem_req, dmem_ready;
  logic             enF, enD, enE, enM, enW, clrD, clrE, clrM, clrW;
  logic [1:0]       forwardAE, forwardBE;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_pass   = 0;
  int n_checks = 0;

  // model state: outstanding dmem wait, cycles spent waiting, sticky timeout, counters
  bit          m_wait;
  int unsigned m_wcnt, m_stall, m_flush;
  bit          m_to;

  pipe_ctrl #(.DWAIT_MAX(DWAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .redirectE(redirectE),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .enF(enF), .enD(enD), .enE(enE), .enM(enM), .enW(enW),
    .clrD(clrD), .clrE(clrE), .clrM(clrM), .clrW(clrW),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (regwriteM && writeregM != 0 && writeregM == src) return 2'b10;
    if (regwriteW && writeregW != 0 && writeregW == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_wcnt = 0; m_stall = 0; m_flush = 0; m_to = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ":en"},  {27'd0, enF, enD, enE, enM, enW}, 32'd0);
    chk({tag, ":clr"}, {28'd0, clrD, clrE, clrM, clrW}, 32'd0);
    chk({tag, ":fwd"}, {28'd0, forwardAE, forwardBE}, 32'd0);
    chk({tag, ":to"},  {31'd0, mem_timeout}, 32'd0);
    chk({tag, ":cnt"}, {20'd0, stall_cnt, flush_cnt}, 32'd0);
  endtask

  task automatic benign();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {regwriteE, regwriteM, regwriteW, memtoregE, redirectE} = '0;
    imem_ready = 1; dmem_req = 0; dmem_ready = 1;
  endtask

  // One cycle: check at negedge against the model, then advance the model at posedge.
  task automatic step(input string tag);
    bit frz, lu;
    logic [4:0] een;
    logic [3:0] eclr;
    @(negedge clk);
    frz = !dmem_ready && (m_wait || dmem_req);
    lu  = memtoregE && writeregE != 0 && (writeregE == rsD || writeregE == rtD);
    if (frz)             begin een = 5'b11110; eclr = 4'b0001; end
    else if (redirectE)  begin een = 5'b00000; eclr = 4'b1100; end
    else if (lu)         begin een = 5'b11000; eclr = 4'b0100; end
    else if (!imem_ready) begin een = 5'b10000; eclr = 4'b1000; end
    else                 begin een = 5'b00000; eclr = 4'b0000; end
    chk({tag, ":en"},    {27'd0, enF, enD, enE, enM, enW}, {27'd0, een});
    chk({tag, ":clr"},   {28'd0, clrD, clrE, clrM, clrW}, {28'd0, eclr});
    chk({tag, ":fwdA"},  {30'd0, forwardAE}, {30'd0, ref_fwd(rsE)});
    chk({tag, ":fwdB"},  {30'd0, forwardBE}, {30'd0, ref_fwd(rtE)});
    chk({tag, ":to"},    {31'd0, mem_timeout}, {31'd0, m_to});
    chk({tag, ":stall"}, 32'(stall_cnt), m_stall);
    chk({tag, ":flush"}, 32'(flush_cnt), m_flush);
    @(posedge clk);
    if (een[4]) m_stall = (m_stall + 1) % CNT_MOD;
    if (!frz && (redirectE || lu)) m_flush = (m_flush + 1) % CNT_MOD;
    if (m_wait) begin
      m_wcnt++;
      if (m_wcnt >= DWAIT_MAX) m_to = 1;
    end
    if (!frz) m_wcnt = 0;
    m_wait = frz;
    #1;
  endtask

  initial begin
    benign();
    reset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;

    step("idle");

    // lw x5 in E, add x6,x5,x1 in D
    memtoregE = 1; regwriteE = 1; writeregE = 5; rsD = 5; rtD = 1;
    step("lu");
    // add in E with the bubble in M and the load in W
    memtoregE = 0; regwriteE = 0; writeregE = 0; rsD = 0; rtD = 0;
    rsE = 5; rtE = 1; regwriteM = 0; regwriteW = 1; writeregW = 5;
    step("lu_fwdW");
    chk("lu_stall1", 32'(stall_cnt), 32'd1);
    chk("lu_fwdA01", {30'd0, forwardAE}, 32'd1);

    // M beats W, then x0 never forwards
    benign();
    regwriteM = 1; regwriteW = 1; writeregM = 7; writeregW = 7; rsE = 7; rtE = 7;
    step("fwd_MW");
    chk("fwd_M_wins", {30'd0, forwardAE}, 32'd2);
    rsE = 0; writeregM = 0; writeregW = 0; rtE = 0;
    step("fwd_x0");

    // redirect coincident with load-use, then imem wait alone
    benign();
    memtoregE = 1; writeregE = 3; rsD = 3; redirectE = 1;
    step("redir_lu");
    benign();
    imem_ready = 0;
    step("imem_wait");

    // 3-cycle dmem wait with a redirect held during the freeze
    benign();
    dmem_req = 1; dmem_ready = 0; redirectE = 1;
    repeat (3) step("dwait3");
    dmem_ready = 1;
    step("dwait3_done");
    benign();
    step("after_dwait3");
    chk("no_timeout", {31'd0, mem_timeout}, 32'd0);

    // 10-cycle wait trips the watchdog, which stays set
    dmem_req = 1; dmem_ready = 0;
    repeat (10) step("dwait10");
    chk("timeout_set", {31'd0, mem_timeout}, 32'd1);
    dmem_ready = 1;
    step("dwait10_done");
    benign();
    repeat (2) step("timeout_sticky");

    // async reset in the middle of a DWAIT cycle
    dmem_req = 1; dmem_ready = 0;
    repeat (2) step("pre_rst");
    #2;
    reset = 0;
    #1;
    chk_reset_vals("rst_dwait");
    model_reset();
    @(posedge clk);
    #1;
    chk_reset_vals("rst_hold");
    @(negedge clk);
    benign();
    dmem_ready = 0;
    reset = 1;
    @(posedge clk);
    #1;
    step("post_rst_run");

    // randomized traffic; narrow register range for frequent hazards
    for (int unsigned i = 0; i < 900; i++) begin
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3));
      writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom_range(0, 1));
      regwriteM = 1'($urandom_range(0, 1));
      regwriteW = 1'($urandom_range(0, 1));
      memtoregE = 1'($urandom_range(0, 1));
      redirectE  = ($urandom_range(0, 7) == 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      dmem_req   = ($urandom_range(0, 2) == 0);
      dmem_ready = ($urandom_range(0, 2) != 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
